// File: rtl/ram_port_arbiter.sv
// Round-robin owner arbiter sharing one single-port RAM between the control unit (requester 0)
// and the debug/program loader (requester 1), with burst limiting and an optional ownership lock.
module ram_port_arbiter #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic              r0_lock,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_gnt,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic              r1_lock,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_gnt,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t state, state_next;
   logic ptr, ptr_next;
   logic [CNT_W-1:0] count, count_next, count_inc;
   logic acc0, acc1;
   logic [DATA_W-1:0] r0_hold, r1_hold;

   assign r0_gnt = (state == OWN0);
   assign r1_gnt = (state == OWN1);
   assign acc0   = enable & r0_gnt & r0_req;
   assign acc1   = enable & r1_gnt & r1_req;

   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (acc0) begin
         ram_en    = 1'b1;
         ram_we    = r0_we;
         ram_addr  = r0_addr;
         ram_wdata = r0_wdata;
      end else if (acc1) begin
         ram_en    = 1'b1;
         ram_we    = r1_we;
         ram_addr  = r1_addr;
         ram_wdata = r1_wdata;
      end
   end

   // The burst limit is judged on the count including this cycle's transfer, so the
   // owner gives up the RAM right after its MAX_BURST-th transfer rather than one later.
   always_comb begin
      count_inc = count;
      if ((acc0 | acc1) && (count != MAX_CNT)) begin
         count_inc = count + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      count_next = count;
      if (enable) begin
         case (state)
            IDLE: begin
               if (r0_req && r1_req) begin
                  state_next = ptr ? OWN1 : OWN0;
               end else if (r0_req) begin
                  state_next = OWN0;
               end else if (r1_req) begin
                  state_next = OWN1;
               end
            end
            OWN0: begin
               if (!r0_req || (!r0_lock && (count_inc == MAX_CNT) && r1_req)) begin
                  state_next = IDLE;
                  ptr_next   = 1'b1;
                  count_next = '0;
               end else begin
                  count_next = count_inc;
               end
            end
            OWN1: begin
               if (!r1_req || (!r1_lock && (count_inc == MAX_CNT) && r0_req)) begin
                  state_next = IDLE;
                  ptr_next   = 1'b0;
                  count_next = '0;
               end else begin
                  count_next = count_inc;
               end
            end
            default: begin
               state_next = IDLE;
               count_next = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         ptr   <= 1'b0;
         count <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
         count <= count_next;
      end
   end

   // RAM data arrives the cycle after the strobe: it is forwarded while rvalid is high
   // and held in a register afterwards so rdata stays stable between reads.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r0_rvalid <= 1'b0;
         r1_rvalid <= 1'b0;
         r0_hold   <= '0;
         r1_hold   <= '0;
      end else begin
         r0_rvalid <= acc0 & ~r0_we;
         r1_rvalid <= acc1 & ~r1_we;
         if (r0_rvalid) begin
            r0_hold <= ram_rdata;
         end
         if (r1_rvalid) begin
            r1_hold <= ram_rdata;
         end
      end
   end

   assign r0_rdata = r0_rvalid ? ram_rdata : r0_hold;
   assign r1_rdata = r1_rvalid ? ram_rdata : r1_hold;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of ownership, bursts and RAM contents.
module tb_ram_port_arbiter;

   localparam int MAXB = 4;

   logic       clk = 1'b0;
   logic       reset, enable;
   logic       r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
   logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
   logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
   logic [7:0] r0_rdata, r1_rdata;
   logic       ram_en, ram_we;
   logic [7:0] ram_addr, ram_wdata, ram_rdata;

   logic [7:0] ram_mem [256];
   logic [7:0] model_mem [256];

   int checks = 0;
   int failures = 0;

   int         m_own, m_cnt, m_ptr;
   logic       m_rv [2];
   logic [7:0] m_rd [2];
   bit         model_valid = 1'b0;

   logic       obs_gnt0, obs_gnt1, obs_rv0, obs_rv1, obs_en, obs_we;
   logic [7:0] obs_rd0, obs_rd1;
   int         obs_x;

   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MAXB)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   // Bench RAM reloads its image whenever reset is low so the model can track it exactly.
   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 256; i++) ram_mem[i] <= 8'(i) ^ 8'h4A;
      end else if (ram_en && ram_we) begin
         ram_mem[ram_addr] <= ram_wdata;
      end else if (ram_en) begin
         ram_rdata <= ram_mem[ram_addr];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic en,
                                input logic q0, input logic w0, input logic l0,
                                input logic [7:0] a0, input logic [7:0] d0,
                                input logic q1, input logic w1, input logic l1,
                                input logic [7:0] a1, input logic [7:0] d1);
      logic       qa [2];
      logic       wa [2];
      logic       la [2];
      logic [7:0] aa [2];
      logic [7:0] da [2];
      int o, nc;
      logic acc;
      reset = rst; enable = en;
      r0_req = q0; r0_we = w0; r0_lock = l0; r0_addr = a0; r0_wdata = d0;
      r1_req = q1; r1_we = w1; r1_lock = l1; r1_addr = a1; r1_wdata = d1;
      qa[0] = q0; wa[0] = w0; la[0] = l0; aa[0] = a0; da[0] = d0;
      qa[1] = q1; wa[1] = w1; la[1] = l1; aa[1] = a1; da[1] = d1;
      @(negedge clk);
      obs_gnt0 = r0_gnt; obs_gnt1 = r1_gnt; obs_rv0 = r0_rvalid; obs_rv1 = r1_rvalid;
      obs_rd0 = r0_rdata; obs_rd1 = r1_rdata; obs_en = ram_en; obs_we = ram_we;
      obs_x = !ram_en ? -1 : (r0_gnt ? 0 : 1);
      o   = (m_own < 0) ? 0 : m_own;
      acc = en && (m_own >= 0) && qa[o];
      if (model_valid) begin
         checkOutput("gnt0", 32'(r0_gnt), 32'(m_own == 0));
         checkOutput("gnt1", 32'(r1_gnt), 32'(m_own == 1));
         checkOutput("no_overlap", 32'(r0_gnt & r1_gnt), 32'd0);
         checkOutput("rvalid0", 32'(r0_rvalid), 32'(m_rv[0]));
         checkOutput("rvalid1", 32'(r1_rvalid), 32'(m_rv[1]));
         checkOutput("rdata0", 32'(r0_rdata), 32'(m_rd[0]));
         checkOutput("rdata1", 32'(r1_rdata), 32'(m_rd[1]));
         checkOutput("ram_en", 32'(ram_en), 32'(acc));
         checkOutput("ram_we", 32'(ram_we), 32'(acc && wa[o]));
         checkOutput("ram_addr", 32'(ram_addr), acc ? 32'(aa[o]) : 32'd0);
         checkOutput("ram_wdata", 32'(ram_wdata), acc ? 32'(da[o]) : 32'd0);
      end
      if (!rst) begin
         m_own = -1; m_cnt = 0; m_ptr = 0;
         m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = 8'h00; m_rd[1] = 8'h00;
         for (int i = 0; i < 256; i++) model_mem[i] = 8'(i) ^ 8'h4A;
         model_valid = 1'b1;
      end else begin
         for (int n = 0; n < 2; n++) begin
            m_rv[n] = acc && (m_own == n) && !wa[n];
            if (m_rv[n]) m_rd[n] = model_mem[aa[n]];
         end
         if (acc && wa[o]) model_mem[aa[o]] = da[o];
         if (en) begin
            if (m_own < 0) begin
               if (qa[0] && qa[1]) m_own = m_ptr;
               else if (qa[0]) m_own = 0;
               else if (qa[1]) m_own = 1;
            end else begin
               nc = (acc && m_cnt < MAXB) ? m_cnt + 1 : m_cnt;
               if (!qa[o] || (!la[o] && nc == MAXB && qa[1-o])) begin
                  m_own = -1; m_cnt = 0; m_ptr = 1 - o;
               end else begin
                  m_cnt = nc;
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
   endtask

   initial begin
      int exp_x, n_wr, n_xf;
      logic q0, q1;
      m_own = -1; m_cnt = 0; m_ptr = 0;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = 8'h00; m_rd[1] = 8'h00;
      #1;

      // Reset, then a single r0 read of 0x10 which holds 0x5A.
      doReset();
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      checkOutput("reset_gnt0", 32'(obs_gnt0), 32'd0);
      checkOutput("reset_rdata0", 32'(obs_rd0), 32'd0);
      applyStimulus(1, 1, 1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      checkOutput("t1_gnt_latency", 32'(obs_gnt0), 32'd0);
      applyStimulus(1, 1, 1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      checkOutput("t1_gnt0", 32'(obs_gnt0), 32'd1);
      checkOutput("t1_ram_en", 32'(obs_en), 32'd1);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      checkOutput("t1_rvalid", 32'(obs_rv0), 32'd1);
      checkOutput("t1_rdata", 32'(obs_rd0), 32'h5A);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      checkOutput("t1_release", 32'(obs_gnt0), 32'd0);

      // Simultaneous requests from reset: r0 first, then one idle cycle, then r1.
      doReset();
      applyStimulus(1, 1, 1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
      applyStimulus(1, 1, 1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
      checkOutput("t2_gnt0", 32'(obs_gnt0), 32'd1);
      checkOutput("t2_gnt1", 32'(obs_gnt1), 32'd0);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h02, 8'h00);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h02, 8'h00);
      checkOutput("t2_gap", 32'(obs_gnt0 | obs_gnt1), 32'd0);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h02, 8'h00);
      checkOutput("t2_gnt1_after_gap", 32'(obs_gnt1), 32'd1);

      // Both stream unlocked: runs of MAXB transfers separated by one gap cycle.
      doReset();
      for (int c = 0; c < 15; c++) begin
         applyStimulus(1, 1, 1, 1'($urandom), 0, 8'($urandom), 8'($urandom),
                       1, 1'($urandom), 0, 8'($urandom), 8'($urandom));
         exp_x = (c == 0 || (c - 1) % (MAXB + 1) == MAXB) ? -1 : ((c - 1) / (MAXB + 1)) % 2;
         checkOutput("t3_pattern", 32'(obs_x), 32'(exp_x));
      end

      // r1 locked for 10 writes while r0 waits.
      doReset();
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h40, 8'h00);
      n_wr = 0;
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1, 1, 1, 0, 0, 8'h41, 8'h00, 1, 1, 1, 8'(8'h40 + c), 8'($urandom));
         checkOutput("t4_r0_blocked", 32'(obs_gnt0), 32'd0);
         if (obs_en && obs_we && obs_gnt1) n_wr++;
      end
      checkOutput("t4_writes", 32'(n_wr), 32'd10);
      applyStimulus(1, 1, 1, 0, 0, 8'h41, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      applyStimulus(1, 1, 1, 0, 0, 8'h41, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      applyStimulus(1, 1, 1, 0, 0, 8'h41, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      checkOutput("t4_r0_after", 32'(obs_gnt0), 32'd1);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

      // Enable low mid-burst: grant held, no transfers, remaining allowance honoured.
      doReset();
      applyStimulus(1, 1, 1, 0, 0, 8'h20, 8'h00, 1, 0, 0, 8'h30, 8'h00);
      n_xf = 0;
      for (int c = 0; c < 2; c++) begin
         applyStimulus(1, 1, 1, 0, 0, 8'(8'h20 + c), 8'h00, 1, 0, 0, 8'h30, 8'h00);
         if (obs_x == 0) n_xf++;
      end
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1, 0, 1, 0, 0, 8'h22, 8'h00, 1, 0, 0, 8'h30, 8'h00);
         checkOutput("t5_en_low_ram_en", 32'(obs_en), 32'd0);
         checkOutput("t5_en_low_gnt0", 32'(obs_gnt0), 32'd1);
      end
      for (int c = 0; c < 10 && r0_gnt; c++) begin
         applyStimulus(1, 1, 1, 0, 0, 8'(8'h22 + c), 8'h00, 1, 0, 0, 8'h30, 8'h00);
         if (obs_x == 0) n_xf++;
      end
      checkOutput("t5_total_burst", 32'(n_xf), 32'(MAXB));
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

      // Reset while r1 owns the RAM with a read in flight.
      doReset();
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h55, 8'h00);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h55, 8'h00);
      applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h56, 8'h00);
      checkOutput("t6_pre_gnt1", 32'(obs_gnt1), 32'd1);
      applyStimulus(1, 1, 1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
      checkOutput("t6_gnt1", 32'(obs_gnt1), 32'd0);
      checkOutput("t6_rvalid1", 32'(obs_rv1), 32'd0);
      applyStimulus(1, 1, 1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
      checkOutput("t6_ptr0", 32'(obs_gnt0), 32'd1);

      // Random traffic against the model.
      q0 = 1'b0; q1 = 1'b0;
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 3) == 0) q0 = ~q0;
         if ($urandom_range(0, 3) == 0) q1 = ~q1;
         applyStimulus(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 7) != 0),
                       q0, 1'($urandom), 1'($urandom_range(0, 5) == 0), 8'($urandom), 8'($urandom),
                       q1, 1'($urandom), 1'($urandom_range(0, 5) == 0), 8'($urandom), 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares the single-port data RAM (8-bit address, 8-bit data) between two requesters. Requester 0 is the control unit's RAM path. Requester 1 is the debug/program loader port.
Arbitration is round-robin with a fixed owner state machine and an optional lock for atomic bursts. The block sits between the control unit and the RAM and owns every RAM enable, write, address and data pin.

Parameters:
ADDR_W, 8, RAM address width (matches ram_addres_bus_size)
DATA_W, 8, RAM data width (matches operand_size)
MAX_BURST, 4, accepted transfers an owner may make before yielding to a waiting requester when not locked (1..15)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
enable  input  1  global enable; low freezes arbitration and blocks new transfers
r0_req  input  1  requester 0 access request, held until granted transfers are done
r0_we  input  1  requester 0 write (1) / read (0)
r0_lock  input  1  requester 0 holds ownership regardless of MAX_BURST
r0_addr  input  ADDR_W  requester 0 address
r0_wdata  input  DATA_W  requester 0 write data
r0_gnt  output  1  requester 0 owns RAM (registered)
r0_rvalid  output  1  requester 0 read data valid
r0_rdata  output  DATA_W  requester 0 read data
r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same as requester 0, for requester 1
ram_en  output  1  RAM access strobe
ram_we  output  1  RAM write strobe
ram_addr  output  ADDR_W  RAM address
ram_wdata  output  DATA_W  RAM write data
ram_rdata  input  DATA_W  RAM read data, valid one clk after a read strobe

Behaviour:
Reset (reset==0 at a clk edge, overrides everything, including mid-burst):
- state=IDLE, r0_gnt=r1_gnt=0, r0_rvalid=r1_rvalid=0, burst count=0, priority pointer=0 (requester 0 first).
- ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, r0_rdata=r1_rdata=0.

States: IDLE, OWN0, OWN1; gnt_n is 1 exactly in OWNn.

IDLE:
- Only r0_req -> OWN0; only r1_req -> OWN1.
- Both -> OWN(pointer).
- No request -> stay in IDLE.
- Grant rises the cycle after the request is seen, so request-to-grant latency is 1 clk.

Transfer:
- A transfer is accepted on a clk edge when enable & gnt_n & req_n.
- ram_en/ram_we/ram_addr/ram_wdata are combinational copies of the owner's req/we/addr/wdata, gated by enable & gnt_n & req_n.
- When gated off: ram_en=0, ram_we=0, addr/wdata=0.
- One transfer per cycle; the requester changes addr/we/wdata each cycle to stream.

Read return:
- rvalid_n pulses for 1 clk, the cycle after an accepted read.
- rdata_n is a registered copy of ram_rdata at that point.
- Writes produce no rvalid.
- A read accepted on the owner's last cycle still returns rvalid after the grant drops.

Burst count:
- Increments per accepted transfer, saturating at MAX_BURST.
- Cleared on entering IDLE.

OWNn exits to IDLE (gnt_n falls next cycle, pointer := other requester) when either:
- req_n==0 (and enable==1); or
- lock_n==0, count==MAX_BURST, and the other requester is requesting.
Otherwise stay in OWNn. With lock_n==1, ownership persists while req_n is held.

Turnaround and fairness:
- There is always one IDLE cycle between owners: no grant overlap, no combinational grant handover.
- With both requesting continuously and unlocked, ownership alternates every MAX_BURST transfers.
- The pointer updates only on release, so a requester alone keeps re-winning.

Enable low:
- State, count, pointer and grants hold.
- ram_en=0, no transfer accepted, no release evaluated.
- rvalid for a read accepted in the previous cycle still fires.

Test Plan:
- Reset, r0 read addr 0x10 (RAM holds 0x5A): r0_gnt=1 one cycle after req, ram_en=1/ram_we=0/ram_addr=0x10 that cycle, r0_rvalid=1 with r0_rdata=0x5A next cycle.
- r0 and r1 assert req in the same cycle from reset: OWN0 first, r1_gnt=0. After r0 drops req, one IDLE cycle, then r1_gnt=1.
- Both stream continuously, unlocked, MAX_BURST=4: transfer pattern is 4 r0, gap, 4 r1, gap, 4 r0. Never both gnt=1.
- r1_lock=1 with 10 consecutive writes while r0_req=1: all 10 writes land with ram_we=1, r0_gnt stays 0 until r1_req drops.
- enable=0 for 3 cycles mid-burst: ram_en=0, grant holds, count unchanged. Transfers resume on re-enable with the remaining burst allowance.
- reset=0 while OWN1 with a read in flight: next cycle all grants and rvalids are 0, state IDLE, pointer 0.
